// File: rtl/usi_iq_param.sv
// Run-time configurable I/Q up-sampler: zero-insert or sample-and-hold, factor 1..MAX_L.
// Settings are taken only at a frame boundary and are checked before they are adopted.
module usi_iq_param #(
  parameter int DW     = 2,
  parameter int MAX_L  = 16,
  parameter int RST_L  = 4,
  parameter int RST_PH = 2,
  localparam int LW    = $clog2(MAX_L + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [LW-1:0] l_cfg,
  input  logic [LW-1:0] ph_cfg,
  input  logic          mode_cfg,
  input  logic [DW-1:0] i_in,
  input  logic [DW-1:0] q_in,
  output logic [DW-1:0] i_out,
  output logic [DW-1:0] q_out,
  output logic          strobe,
  output logic          cfg_err
);

  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_l;
  logic [LW-1:0] r_ph;
  logic          r_mode;
  logic [DW-1:0] r_i;
  logic [DW-1:0] r_q;
  logic          r_strobe;
  logic          r_cfg_err;

  logic          w_boundary;
  logic          w_capture;
  logic          w_cfg_valid;

  // With L=1 the counter never leaves 0, so every enabled edge is both a boundary and a capture.
  assign w_boundary  = (r_cnt == r_l - LW'(1));
  assign w_capture   = (r_cnt == r_ph);
  assign w_cfg_valid = (l_cfg != '0) && (l_cfg <= LW'(MAX_L)) && (ph_cfg < l_cfg);

  // NOTE: every register here is assigned with <= so all updates see the pre-edge
  // counter and active config, which is exactly what the capture/apply decisions need.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_l       <= LW'(RST_L);
      r_ph      <= LW'(RST_PH);
      r_mode    <= 1'b0;
      r_i       <= '0;
      r_q       <= '0;
      r_strobe  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (en) begin
      r_cnt <= w_boundary ? '0 : r_cnt + LW'(1);

      if (w_capture) begin
        r_i      <= i_in;
        r_q      <= q_in;
        r_strobe <= 1'b1;
      end else begin
        r_strobe <= 1'b0;
        if (!r_mode) begin
          r_i <= '0;
          r_q <= '0;
        end
      end

      if (w_boundary) begin
        if (w_cfg_valid) begin
          r_l       <= l_cfg;
          r_ph      <= ph_cfg;
          r_mode    <= mode_cfg;
          r_cfg_err <= 1'b0;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else begin
        r_cfg_err <= 1'b0;
      end
    end else begin
      r_strobe  <= 1'b0;
      r_cfg_err <= 1'b0;
    end
  end

  assign i_out   = r_i;
  assign q_out   = r_q;
  assign strobe  = r_strobe;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_usi_iq_param.sv
// Directed, table-driven bench for usi_iq_param with default parameters (DW=2, MAX_L=16, 4/2/0 reset).
// Each row is one clock edge: inputs applied before the edge, outputs compared 1 ns after it.
module tb_usi_iq_param;

  localparam int LW = 5;

  typedef struct {
    logic          rst;
    logic          en;
    logic [LW-1:0] l;
    logic [LW-1:0] ph;
    logic          mode;
    logic [1:0]    i;
    logic [1:0]    q;
    logic [1:0]    ei;
    logic [1:0]    eq;
    logic          es;
    logic          ee;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [LW-1:0] l_cfg = 5'd4;
  logic [LW-1:0] ph_cfg = 5'd2;
  logic          mode_cfg = 1'b0;
  logic [1:0]    i_in = '0;
  logic [1:0]    q_in = '0;
  logic [1:0]    i_out;
  logic [1:0]    q_out;
  logic          strobe;
  logic          cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t          vecs[$];
  logic [LW-1:0] c_l  = 5'd4;
  logic [LW-1:0] c_ph = 5'd2;
  logic          c_m  = 1'b0;

  usi_iq_param dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .l_cfg    (l_cfg),
    .ph_cfg   (ph_cfg),
    .mode_cfg (mode_cfg),
    .i_in     (i_in),
    .q_in     (q_in),
    .i_out    (i_out),
    .q_out    (q_out),
    .strobe   (strobe),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] actual, input logic [5:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: {i,q,strobe,err} got %b_%b_%b_%b expected %b_%b_%b_%b", name,
               actual[5:4], actual[3:2], actual[1], actual[0],
               expected[5:4], expected[3:2], expected[1], expected[0]);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] i, input logic [1:0] q,
                     input logic [1:0] ei, input logic [1:0] eq, input logic es, input logic ee);
    vec_t v;
    v.rst = r;   v.en = e;   v.l = c_l; v.ph = c_ph; v.mode = c_m;
    v.i   = i;   v.q  = q;   v.ei = ei; v.eq = eq;   v.es = es; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    rst      = v.rst;
    en       = v.en;
    l_cfg    = v.l;
    ph_cfg   = v.ph;
    mode_cfg = v.mode;
    i_in     = v.i;
    q_in     = v.q;
    @(posedge clk);
    #1;
    check(name, {i_out, q_out, strobe, cfg_err}, {v.ei, v.eq, v.es, v.ee});
  endtask

  initial begin
    vec_t hv;

    // Reset, then two default frames: capture on the third edge, zeros elsewhere.
    add(1, 1, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b11, 2'b01, 2'b11, 1, 0);
    add(0, 1, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b01, 2'b10, 2'b01, 1, 0);
    add(0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);

    // Enable low for 3 cycles at cnt=3; a bad config offered meanwhile must be ignored.
    add(0, 1, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b11, 2'b10, 2'b11, 2'b10, 1, 0);
    c_l = 5'd0;
    add(0, 0, 2'b00, 2'b00, 2'b11, 2'b10, 0, 0);
    add(0, 0, 2'b00, 2'b00, 2'b11, 2'b10, 0, 0);
    add(0, 0, 2'b00, 2'b00, 2'b11, 2'b10, 0, 0);
    c_l = 5'd4;
    add(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0);

    // Rejected configs: L=0, PH>=L, L>MAX_L. Invalid values off-boundary raise nothing.
    c_l = 5'd0; c_ph = 5'd0;
    add(0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1);
    add(0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    c_l = 5'd4; c_ph = 5'd5;
    add(0, 1, 2'b10, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b11, 2'b10, 2'b11, 1, 0);
    add(0, 1, 2'b10, 2'b11, 2'b00, 2'b00, 0, 1);
    c_ph = 5'd2;
    add(0, 1, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b10, 2'b01, 2'b10, 1, 0);
    c_l = 5'd17; c_ph = 5'd0;
    add(0, 1, 2'b01, 2'b10, 2'b00, 2'b00, 0, 1);

    // Mid-frame request for L=8, PH=0, hold mode: current frame ends with L=4.
    c_l = 5'd4; c_ph = 5'd2;
    add(0, 1, 2'b11, 2'b01, 2'b00, 2'b00, 0, 0);
    c_l = 5'd8; c_ph = 5'd0; c_m = 1'b1;
    add(0, 1, 2'b11, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b11, 2'b01, 2'b11, 2'b01, 1, 0);
    add(0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b10, 2'b10, 2'b10, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 1, 2'b01, 2'b01, 2'b10, 2'b10, 0, 0);
    add(0, 1, 2'b01, 2'b11, 2'b01, 2'b11, 1, 0);

    // Reset at cnt=2 of an L=8 frame with 2/1/0 pending: back to 4/2/0 zero-insert.
    c_l = 5'd2; c_ph = 5'd1; c_m = 1'b0;
    add(0, 1, 2'b00, 2'b00, 2'b01, 2'b11, 0, 0);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b10, 2'b01, 2'b10, 2'b01, 1, 0);
    c_l = 5'd1; c_ph = 5'd0;
    add(0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);

    // L=1 pass-through with a ramp, one stalled cycle, then switch to L=MAX_L, PH=15.
    add(0, 1, 2'b00, 2'b11, 2'b00, 2'b11, 1, 0);
    add(0, 1, 2'b01, 2'b10, 2'b01, 2'b10, 1, 0);
    add(0, 1, 2'b10, 2'b01, 2'b10, 2'b01, 1, 0);
    add(0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 1, 0);
    add(0, 0, 2'b01, 2'b01, 2'b11, 2'b00, 0, 0);
    add(0, 1, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0);
    c_l = 5'd16; c_ph = 5'd15;
    add(0, 1, 2'b10, 2'b10, 2'b10, 2'b10, 1, 0);
    for (int k = 0; k < 15; k++) add(0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, 1, 2'b11, 2'b11, 2'b11, 2'b11, 1, 0);

    for (int k = 0; k < vecs.size(); k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

    // Hand-written: reset must win over en=0, then a fresh default frame follows.
    hv = '{rst: 1'b1, en: 1'b0, l: 5'd4, ph: 5'd2, mode: 1'b0,
           i: 2'b11, q: 2'b11, ei: 2'b00, eq: 2'b00, es: 1'b0, ee: 1'b0};
    apply_vec(hv, "rst_over_en");
    hv.rst = 1'b0; hv.en = 1'b1;
    apply_vec(hv, "post_rst_e1");
    apply_vec(hv, "post_rst_e2");
    hv.ei = 2'b11; hv.eq = 2'b11; hv.es = 1'b1;
    apply_vec(hv, "post_rst_e3");
    hv.ei = 2'b00; hv.eq = 2'b00; hv.es = 1'b0;
    apply_vec(hv, "post_rst_e4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
